// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-class accumulator CPU core.
// Single-cycle datapath with fetch-valid stall, sticky HALT and a registered out_valid strobe.
module td4x_core #(
    parameter int W  = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W+3:0]  instr,
    input  logic          instr_valid,
    input  logic [W-1:0]  in_data,
    output logic [AW-1:0] pc,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    output logic          c_flag,
    output logic          halted
);
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Wide enough to hold both the immediate and a jump target, so im can be
    // zero-extended or truncated to AW bits without a generate split.
    localparam int XW = (AW > W) ? AW : W;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, b_q, a_d, b_d, out_d;
    logic [W-1:0]  src, im, sum;
    logic [AW-1:0] pc_d, jmp_target;
    logic [XW-1:0] im_ext;
    logic [3:0]    op;
    logic          c_d, ov_d, cy, exec;

    assign op         = instr[W+3:W];
    assign im         = instr[W-1:0];
    assign im_ext     = XW'(im);
    assign jmp_target = im_ext[AW-1:0];
    assign halted     = (state_q == HALTED);
    assign exec       = instr_valid && (state_q == RUN);

    always_comb begin
        src = '0;
        case (op)
            4'b0000, 4'b0100:          src = a_q;
            4'b0101, 4'b0001, 4'b1001: src = b_q;
            4'b0010, 4'b0110:          src = in_data;
            default:                   src = '0;
        endcase
    end

    assign {cy, sum} = {1'b0, src} + {1'b0, im};

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_data;
        pc_d    = pc;
        c_d     = c_flag;
        ov_d    = 1'b0;
        state_d = state_q;
        if (exec) begin
            c_d  = cy;
            pc_d = pc + AW'(1);
            case (op)
                4'b0000, 4'b0011, 4'b0001, 4'b0010: a_d = sum;
                4'b0101, 4'b0111, 4'b0100, 4'b0110: b_d = sum;
                4'b1001, 4'b1011: begin
                    out_d = sum;
                    ov_d  = 1'b1;
                end
                4'b1111: pc_d = jmp_target;
                // JNC looks at the flag as it stood before this edge.
                4'b1110: if (!c_flag) pc_d = jmp_target;
                4'b1000: begin
                    pc_d    = pc;
                    c_d     = 1'b0;
                    state_d = HALTED;
                end
                default: c_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            a_q       <= '0;
            b_q       <= '0;
            out_data  <= '0;
            pc        <= '0;
            c_flag    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_data  <= out_d;
            pc        <= pc_d;
            c_flag    <= c_d;
            out_valid <= ov_d;
        end
    end
endmodule

// File: doc/td4x_core.md
Name: td4x_core

Overview:
- Parametrised next-generation TD4-class accumulator CPU core with configurable data width and program-address width.
- Executes the full TD4 instruction set, one instruction per accepted fetch.
- Adds over the 4-bit original: a fetch-valid stall handshake, a HALT instruction, an output-valid strobe, and PC wrap at 2^AW.
- Sits between the program ROM (combinational, or slower with valid) and board I/O (switches in, LEDs out).

Parameters:
- W, 4: data width of registers A, B, OUT and the immediate field.
- AW, 4: program-counter width; ROM depth is 2^AW.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  4+W  instruction; [W+3:W] opcode, [W-1:0] immediate im.
- instr_valid  in  1  instr is valid for the current pc; 0 stalls the core.
- in_data  in  W  input port (switches).
- pc  out  AW  current program address to ROM.
- out_data  out  W  output port register.
- out_valid  out  1  one-cycle pulse in the cycle after an OUT executes.
- c_flag  out  1  carry flag.
- halted  out  1  core stopped by HALT.

Behaviour:
- Reset (reset=0, async): A, B, out_data, pc, c_flag, out_valid and halted all go to 0. Deassertion is synchronised by the integrator.
- Execute: an instruction executes on a rising edge when instr_valid=1 and halted=0. Otherwise all state holds and out_valid=0.
- Datapath: sum = src + im, W bits, with carry-out cy. After every executed instruction, c_flag <= cy.
- Opcodes, as op: action; src:
  - 0000 ADD A,im: A<=sum; src=A.
  - 0101 ADD B,im: B<=sum; src=B.
  - 0011 MOV A,im: A<=sum; src=0.
  - 0111 MOV B,im: B<=sum; src=0.
  - 0001 MOV A,B: A<=sum; src=B; im is used as encoded (0 by convention).
  - 0100 MOV B,A: B<=sum; src=A.
  - 0010 IN A: A<=sum; src=in_data.
  - 0110 IN B: B<=sum; src=in_data.
  - 1001 OUT B: out_data<=sum; src=B; out_valid<=1.
  - 1011 OUT im: out_data<=sum; src=0; out_valid<=1.
  - 1111 JMP im: pc<=im; src=0.
  - 1110 JNC im: if c_flag==0 (value before this edge) pc<=im, else pc<=pc+1; src=0.
  - 1000 HALT: halted<=1; pc holds; c_flag<=0.
  - 1010, 1100, 1101: NOP; pc<=pc+1; c_flag<=0.
- Jump targets: im is zero-extended or truncated to AW bits.
- PC: every non-jump, non-HALT executed instruction does pc<=pc+1 modulo 2^AW, so the highest address wraps to 0.
- out_valid: high exactly one cycle after the executing edge; back-to-back OUTs keep it high continuously.
- Stall: with instr_valid=0, pc, registers and flags are unchanged. A stall cycle never consumes a JNC condition.
- HALT: halted is sticky until reset; instr_valid is ignored while halted=1.
- Reset mid-stall or while halted: returns immediately to the reset state; the next executed instruction is at pc 0.
- Registers A and B are internal. Implementation is a single-cycle datapath plus a two-state RUN/HALTED controller.

Test Plan:
- Reset, W=4, AW=4: assert reset=0 mid-program -> all outputs 0 immediately; after release with instr_valid=1, first fetch is at pc=0.
- Carry and JNC: MOV A,0xE; ADD A,0x3 -> A=0x1, c_flag=1. Then JNC 0x0 -> pc=3 (not taken), c_flag=0. Then JNC 0x0 -> pc=0 (taken).
- Stall: hold instr_valid=0 for 5 cycles in front of ADD B,0x1 -> pc, B, c_flag unchanged for all 5 cycles; increment happens on the first valid edge only.
- OUT strobe: MOV B,0x9; OUT B; OUT 0x5 -> out_data=9, then 5; out_valid high for exactly 2 consecutive cycles.
- Wrap and HALT: 15 NOPs from pc 0 then one more -> pc=0 (wrap). HALT at pc 2 -> halted=1, pc stays 2 for 10 cycles with instr_valid=1.
- Width W=8, AW=6: IN A with in_data=0xFF, then ADD A,0x01 -> A=0x00, c_flag=1. JMP 0x7F -> pc=0x3F (truncated).
